// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding memory request, a 1-entry skid buffer behind the
// IF/ID register, and redirect handling that discards responses from the abandoned path.
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IDIF_stall,
  input  logic        EXIF_branch,
  input  logic [63:0] EXIF_target,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IFID_instreg,
  output logic [63:0] IFID_npc,
  output logic        IFID_ready
);

  typedef enum logic [1:0] {StFetch, StWait, StDrop} state_e;

  state_e      state_q;
  logic [63:0] pc_q;
  logic [63:0] tag_q;
  logic        skid_valid_q;
  logic [31:0] skid_inst_q;
  logic [63:0] skid_npc_q;
  logic        ifid_ready_q;
  logic [31:0] ifid_inst_q;
  logic [63:0] ifid_npc_q;

  logic        consume;
  logic        fire;
  logic        resp;
  logic [63:0] resp_npc;

  // No new request while the skid holds data, so a response always has somewhere to land.
  assign imem_req  = reset & (state_q == StFetch) & ~skid_valid_q;
  assign imem_addr = pc_q;

  assign consume  = ifid_ready_q & ~IDIF_stall;
  assign fire     = imem_req & imem_gnt;
  assign resp     = (state_q == StWait) & imem_rvalid;
  assign resp_npc = tag_q + 64'd4;

  assign IFID_instreg = ifid_inst_q;
  assign IFID_npc     = ifid_npc_q;
  assign IFID_ready   = ifid_ready_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC & ~64'd3;
      tag_q        <= 64'd0;
      skid_valid_q <= 1'b0;
      skid_inst_q  <= NOP_INST;
      skid_npc_q   <= 64'd0;
      ifid_ready_q <= 1'b0;
      ifid_inst_q  <= NOP_INST;
      ifid_npc_q   <= 64'd0;
    end else if (EXIF_branch) begin
      // Redirect wins over stall and response; anything still in flight must be discarded.
      pc_q         <= EXIF_target & ~64'd3;
      skid_valid_q <= 1'b0;
      ifid_ready_q <= 1'b0;
      ifid_inst_q  <= NOP_INST;
      unique case (state_q)
        StFetch: state_q <= fire ? StDrop : StFetch;
        StWait:  state_q <= imem_rvalid ? StFetch : StDrop;
        default: state_q <= imem_rvalid ? StFetch : StDrop;
      endcase
    end else begin
      unique case (state_q)
        StFetch: begin
          if (fire) begin
            tag_q   <= pc_q;
            pc_q    <= pc_q + 64'd4;
            state_q <= StWait;
          end
        end
        StWait, StDrop: begin
          if (imem_rvalid) state_q <= StFetch;
        end
        default: state_q <= StFetch;
      endcase

      if (!ifid_ready_q || consume) begin
        // Skid entry is older than any same-cycle response, so it drains first.
        if (skid_valid_q) begin
          ifid_inst_q  <= skid_inst_q;
          ifid_npc_q   <= skid_npc_q;
          ifid_ready_q <= 1'b1;
          skid_valid_q <= 1'b0;
        end else if (resp) begin
          ifid_inst_q  <= imem_rdata;
          ifid_npc_q   <= resp_npc;
          ifid_ready_q <= 1'b1;
        end else begin
          ifid_inst_q  <= NOP_INST;
          ifid_ready_q <= 1'b0;
        end
      end else if (resp) begin
        skid_inst_q  <= imem_rdata;
        skid_npc_q   <= resp_npc;
        skid_valid_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a single-outstanding memory model plus an in-order
// scoreboard of expected {instruction, npc} pairs checked when decode consumes IF/ID.
module tb_fetch_stage;

  localparam logic [63:0] RstPc = 64'h1000;
  localparam logic [31:0] Nop   = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic        IDIF_stall;
  logic        EXIF_branch;
  logic [63:0] EXIF_target;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] IFID_instreg;
  logic [63:0] IFID_npc;
  logic        IFID_ready;

  fetch_stage #(
    .RESET_PC (RstPc),
    .NOP_INST (Nop)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .IDIF_stall   (IDIF_stall),
    .EXIF_branch  (EXIF_branch),
    .EXIF_target  (EXIF_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .IFID_instreg (IFID_instreg),
    .IFID_npc     (IFID_npc),
    .IFID_ready   (IFID_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] npc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        rst_v = 1'b0;
  logic        stall_v = 1'b0;
  logic        branch_v = 1'b0;
  logic        gnt_en = 1'b0;
  logic [63:0] target_v = 64'd0;
  bit          rand_stall = 1'b0;
  bit          rand_gnt = 1'b0;
  int          lat = 1;
  bit          pend = 1'b0;
  bit          stale = 1'b0;
  int          cnt = 0;
  logic [63:0] paddr = 64'd0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0000;
  endfunction

  task automatic push(input logic [63:0] npc);
    exp_t e;
    e.inst = mem_word(npc - 64'd4);
    e.npc  = npc;
    sb.push_back(e);
  endtask

  // One clock cycle: drive inputs, run the memory model, score any consumption, and return
  // just after the following falling edge with post-edge outputs settled.
  task automatic tick();
    exp_t e;
    if (rand_stall) stall_v = ($urandom_range(0, 2) == 0);
    if (rand_gnt) gnt_en = ($urandom_range(0, 1) == 1);
    reset       = rst_v;
    IDIF_stall  = stall_v;
    EXIF_branch = branch_v;
    EXIF_target = target_v;
    imem_gnt    = gnt_en;
    imem_rvalid = 1'b0;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        pend        = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = stale ? 32'hDEAD_BEEF : mem_word(paddr);
        stale       = 1'b0;
      end
    end
    #1;
    if (!rst_v && pend) stale = 1'b1;
    if (imem_req && imem_gnt) begin
      pend  = 1'b1;
      cnt   = lat;
      paddr = imem_addr;
    end
    if (rst_v && IFID_ready && !stall_v && !branch_v) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_delivery: got npc %h inst %h, required nothing", IFID_npc,
                 IFID_instreg);
      end else begin
        e = sb.pop_front();
        if (IFID_npc !== e.npc || IFID_instreg !== e.inst) begin
          n_bad++;
          $display("FAIL delivery: got npc %h inst %h, required npc %h inst %h", IFID_npc,
                   IFID_instreg, e.npc, e.inst);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_v = 1'b0; stall_v = 1'b1; branch_v = 1'b0; gnt_en = 1'b0;
    rand_stall = 1'b0; rand_gnt = 1'b0; lat = 1;
    tick();
    tick();
    sb.delete();
    pend = 1'b0;
    stale = 1'b0;
    rst_v = 1'b1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() > 0; i++) tick();
    stall_v = 1'b1;
  endtask

  task automatic test_reset();
    rst_v = 1'b0; stall_v = 1'b0; gnt_en = 1'b1; branch_v = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (IFID_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_ready: got %b, required 0", IFID_ready);
    end
    n_cmp++;
    if (IFID_instreg !== Nop) begin
      n_bad++; $display("FAIL reset_inst: got %h, required %h", IFID_instreg, Nop);
    end
    n_cmp++;
    if (IFID_npc !== 64'd0) begin
      n_bad++; $display("FAIL reset_npc: got %h, required 0", IFID_npc);
    end
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_bad++; $display("FAIL reset_req: got %b, required 0", imem_req);
    end
    gnt_en = 1'b0;
    rst_v = 1'b1;
    tick();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== RstPc) begin
      n_bad++;
      $display("FAIL first_req: got req %b addr %h, required req 1 addr %h", imem_req,
               imem_addr, RstPc);
    end
  endtask

  task automatic test_stream();
    do_reset();
    gnt_en = 1'b1; stall_v = 1'b0; lat = 1;
    push(64'h1004); push(64'h1008); push(64'h100C); push(64'h1010);
    tick();
    n_cmp++;
    if (IFID_ready !== 1'b0) begin
      n_bad++; $display("FAIL latency_early: got ready %b, required 0", IFID_ready);
    end
    tick();
    n_cmp++;
    if (IFID_ready !== 1'b1) begin
      n_bad++; $display("FAIL latency_ready: got ready %b, required 1", IFID_ready);
    end
    drain(40);
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++; $display("FAIL stream_drain: got %0d left, required 0", sb.size());
    end
  endtask

  task automatic test_stall();
    do_reset();
    gnt_en = 1'b1; stall_v = 1'b0; lat = 1;
    push(64'h1004);
    for (int i = 0; i < 20 && !(IFID_ready === 1'b1 && IFID_npc === 64'h1008); i++) tick();
    stall_v = 1'b1;
    n_cmp++;
    if (IFID_ready !== 1'b1 || IFID_npc !== 64'h1008) begin
      n_bad++;
      $display("FAIL stall_setup: got ready %b npc %h, required ready 1 npc 1008", IFID_ready,
               IFID_npc);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (IFID_ready !== 1'b1 || IFID_npc !== 64'h1008 || IFID_instreg !== mem_word(64'h1004))
      begin
        n_bad++;
        $display("FAIL stall_hold: got ready %b npc %h inst %h, required 1 1008 %h", IFID_ready,
                 IFID_npc, IFID_instreg, mem_word(64'h1004));
      end
    end
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_bad++; $display("FAIL stall_req: got %b, required 0", imem_req);
    end
    push(64'h1008); push(64'h100C); push(64'h1010);
    stall_v = 1'b0;
    drain(40);
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++; $display("FAIL stall_drain: got %0d left, required 0", sb.size());
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    gnt_en = 1'b1; stall_v = 1'b0; lat = 3;
    push(64'h2004); push(64'h2008);
    tick();
    branch_v = 1'b1; target_v = 64'h2002;
    tick();
    branch_v = 1'b0; lat = 1;
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_bad++; $display("FAIL drop_req: got %b, required 0", imem_req);
    end
    for (int i = 0; i < 10 && imem_req !== 1'b1; i++) begin
      tick();
      n_cmp++;
      if (IFID_ready !== 1'b0) begin
        n_bad++; $display("FAIL drop_ready: got %b, required 0", IFID_ready);
      end
    end
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h2000) begin
      n_bad++;
      $display("FAIL redirect_addr: got req %b addr %h, required 1 2000", imem_req, imem_addr);
    end
    drain(40);
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++; $display("FAIL redirect_drain: got %0d left, required 0", sb.size());
    end
  endtask

  task automatic test_redirect_rvalid_stall();
    do_reset();
    gnt_en = 1'b1; stall_v = 1'b1; lat = 1;
    for (int i = 0; i < 10 && IFID_ready !== 1'b1; i++) tick();
    for (int i = 0; i < 5 && !pend; i++) tick();
    n_cmp++;
    if (IFID_ready !== 1'b1 || !pend) begin
      n_bad++;
      $display("FAIL coinc_setup: got ready %b pending %b, required 1 1", IFID_ready, pend);
    end
    branch_v = 1'b1; target_v = 64'h3000;
    tick();
    branch_v = 1'b0;
    n_cmp++;
    if (IFID_ready !== 1'b0 || IFID_instreg !== Nop) begin
      n_bad++;
      $display("FAIL coinc_ifid: got ready %b inst %h, required 0 %h", IFID_ready, IFID_instreg,
               Nop);
    end
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h3000) begin
      n_bad++;
      $display("FAIL coinc_req: got req %b addr %h, required 1 3000", imem_req, imem_addr);
    end
    push(64'h3004);
    stall_v = 1'b0;
    drain(30);
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++; $display("FAIL coinc_drain: got %0d left, required 0", sb.size());
    end
  endtask

  task automatic test_reset_midwait();
    do_reset();
    gnt_en = 1'b1; stall_v = 1'b0; lat = 4;
    push(64'h1004);
    tick();
    tick();
    rst_v = 1'b0; gnt_en = 1'b0;
    tick();
    rst_v = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (IFID_ready !== 1'b0) begin
      n_bad++; $display("FAIL stale_rvalid: got ready %b, required 0", IFID_ready);
    end
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== RstPc) begin
      n_bad++;
      $display("FAIL stale_req: got req %b addr %h, required 1 %h", imem_req, imem_addr, RstPc);
    end
    gnt_en = 1'b1; lat = 1;
    drain(30);
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++; $display("FAIL midwait_drain: got %0d left, required 0", sb.size());
    end
  endtask

  task automatic test_wrap();
    do_reset();
    gnt_en = 1'b0; stall_v = 1'b0; lat = 1;
    branch_v = 1'b1; target_v = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    branch_v = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      n_bad++;
      $display("FAIL wrap_first: got req %b addr %h, required 1 fffffffffffffffc", imem_req,
               imem_addr);
    end
    gnt_en = 1'b1;
    push(64'h0); push(64'h4);
    tick();
    tick();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      n_bad++; $display("FAIL wrap_addr: got req %b addr %h, required 1 0", imem_req, imem_addr);
    end
    drain(30);
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++; $display("FAIL wrap_drain: got %0d left, required 0", sb.size());
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    stall_v = 1'b0; lat = 1;
    for (int k = 1; k <= 24; k++) push(RstPc + 64'(4 * k));
    rand_stall = 1'b1; rand_gnt = 1'b1;
    for (int i = 0; i < 600 && sb.size() > 0; i++) begin
      lat = $urandom_range(1, 3);
      tick();
    end
    rand_stall = 1'b0; rand_gnt = 1'b0; stall_v = 1'b1;
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++; $display("FAIL b2b_drain: got %0d left, required 0", sb.size());
    end
  endtask

  initial begin
    reset = 1'b0; IDIF_stall = 1'b0; EXIF_branch = 1'b0; EXIF_target = 64'd0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid_stall();
    test_reset_midwait();
    test_wrap();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
